ex_mem_wb_pipe_ctrl: RTL and testbench

//  Holds the ID/EX, EX/MEM and MEM/WB instruction-word and write-enable registers for the 5-stage core and

---
 rtl/ex_mem_wb_pipe_ctrl.sv | 125 ++++++++++++
 tb/tb_ex_mem_wb_pipe_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ex_mem_wb_pipe_ctrl.sv
// ex_mem_wb_pipe_ctrl
//   Back-end pipeline control for the 5-stage core. Holds the ID/EX, EX/MEM
//   and MEM/WB instruction words and write enables, and feeds them directly
//   to the forwarding unit. It detects load-use hazards and inserts one
//   bubble for each. It applies taken-branch flushes and whole-back-end
//   memory stalls. It also keeps saturating stall and flush event counters.
//
// Ports
//   clk             in   1      rising-edge clock
//   rst             in   1      synchronous active-high reset
//   inst_data_ID    in   32     instruction leaving decode
//   regwrite_ID     in   1      decoded instruction writes rd
//   memread_ID      in   1      decoded instruction is a load
//   branch_taken_EX in   1      redirect resolved in EX this cycle
//   mem_stall       in   1      data memory not ready, freeze back end
//   inst_data_EX    out  32     ID/EX instruction register
//   inst_data_MEM   out  32     EX/MEM instruction register
//   inst_data_WB    out  32     MEM/WB instruction register
//   regwrite_MEM    out  1      EX/MEM write enable
//   regwrite_WB     out  1      MEM/WB write enable
//   memread_EX      out  1      ID/EX load flag
//   stall_IF_ID     out  1      hold PC and IF/ID this cycle (combinational)
//   flush_IF_ID     out  1      load NOP into IF/ID next edge (combinational)
//   stall_cnt       out  CNT_W  load-use bubbles inserted (saturating)
//   flush_cnt       out  CNT_W  taken-branch flushes (saturating)
module ex_mem_wb_pipe_ctrl #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_data_ID,
    input  logic             regwrite_ID,
    input  logic             memread_ID,
    input  logic             branch_taken_EX,
    input  logic             mem_stall,
    output logic [31:0]      inst_data_EX,
    output logic [31:0]      inst_data_MEM,
    output logic [31:0]      inst_data_WB,
    output logic             regwrite_MEM,
    output logic             regwrite_WB,
    output logic             memread_EX,
    output logic             stall_IF_ID,
    output logic             flush_IF_ID,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    logic       regwrite_EX;
    logic [6:0] opcode_ID;
    logic [4:0] rs1_ID;
    logic [4:0] rs2_ID;
    logic [4:0] rd_EX;
    logic       rs1_used_ID;
    logic       rs2_used_ID;
    logic       load_use;

    assign opcode_ID = inst_data_ID[6:0];
    assign rs1_ID    = inst_data_ID[19:15];
    assign rs2_ID    = inst_data_ID[24:20];
    assign rd_EX     = inst_data_EX[11:7];

    // Source fields that hold immediate bits must not raise a false hazard.
    assign rs1_used_ID = !(opcode_ID == OP_LUI || opcode_ID == OP_AUIPC || opcode_ID == OP_JAL);
    assign rs2_used_ID = (opcode_ID == OP_R || opcode_ID == OP_S || opcode_ID == OP_B);

    // A bubble clears memread_EX, so each load can cause at most one bubble.
    assign load_use = memread_EX && (rd_EX != 5'd0) &&
                      ((rs1_used_ID && (rs1_ID == rd_EX)) ||
                       (rs2_used_ID && (rs2_ID == rd_EX)));

    // A taken branch overrides load-use because the ID instruction is on the wrong path.
    always_comb begin
        stall_IF_ID = 1'b0;
        flush_IF_ID = 1'b0;
        if (mem_stall) begin
            stall_IF_ID = 1'b1;
        end else if (branch_taken_EX) begin
            flush_IF_ID = 1'b1;
        end else if (load_use) begin
            stall_IF_ID = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_data_EX  <= NOP_INST;
            inst_data_MEM <= NOP_INST;
            inst_data_WB  <= NOP_INST;
            regwrite_EX   <= 1'b0;
            regwrite_MEM  <= 1'b0;
            regwrite_WB   <= 1'b0;
            memread_EX    <= 1'b0;
            stall_cnt     <= '0;
            flush_cnt     <= '0;
        end else if (!mem_stall) begin
            inst_data_MEM <= inst_data_EX;
            inst_data_WB  <= inst_data_MEM;
            regwrite_MEM  <= regwrite_EX;
            regwrite_WB   <= regwrite_MEM;
            if (branch_taken_EX || load_use) begin
                inst_data_EX <= NOP_INST;
                regwrite_EX  <= 1'b0;
                memread_EX   <= 1'b0;
            end else begin
                inst_data_EX <= inst_data_ID;
                regwrite_EX  <= regwrite_ID;
                memread_EX   <= memread_ID;
            end
            if (branch_taken_EX) begin
                if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
            end else if (load_use) begin
                if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_wb_pipe_ctrl.sv
module tb_ex_mem_wb_pipe_ctrl;

    localparam logic [31:0] N   = 32'h0000_0013; // nop
    localparam logic [31:0] L5  = 32'h0000_A283; // lw   x5,0(x1)
    localparam logic [31:0] A6  = 32'h0022_8333; // add  x6,x5,x2
    localparam logic [31:0] L0  = 32'h0000_A003; // lw   x0,0(x1)
    localparam logic [31:0] A60 = 32'h0020_0333; // add  x6,x0,x2
    localparam logic [31:0] LUI = 32'h0000_12B7; // lui  x5,1
    localparam logic [31:0] A7  = 32'h0050_83B3; // add  x7,x1,x5
    localparam logic [31:0] AD8 = 32'h0012_8413; // addi x8,x5,1
    localparam logic [31:0] I1  = 32'h0010_0093; // addi x1,x0,1

    logic        clk = 1'b0;
    logic        rst, regwrite_ID, memread_ID, branch_taken_EX, mem_stall;
    logic [31:0] inst_data_ID;
    logic [31:0] inst_data_EX, inst_data_MEM, inst_data_WB;
    logic        regwrite_MEM, regwrite_WB, memread_EX, stall_IF_ID, flush_IF_ID;
    logic [15:0] stall_cnt, flush_cnt;
    logic [31:0] s_ex, s_mem, s_wb;
    logic        s_rwm, s_rww, s_mrx, s_st, s_fl;
    logic [1:0]  s_sc, s_fc;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ex_mem_wb_pipe_ctrl dut (
        .clk(clk), .rst(rst), .inst_data_ID(inst_data_ID), .regwrite_ID(regwrite_ID),
        .memread_ID(memread_ID), .branch_taken_EX(branch_taken_EX), .mem_stall(mem_stall),
        .inst_data_EX(inst_data_EX), .inst_data_MEM(inst_data_MEM), .inst_data_WB(inst_data_WB),
        .regwrite_MEM(regwrite_MEM), .regwrite_WB(regwrite_WB), .memread_EX(memread_EX),
        .stall_IF_ID(stall_IF_ID), .flush_IF_ID(flush_IF_ID),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter copy so saturation is reachable in a few events.
    ex_mem_wb_pipe_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .inst_data_ID(inst_data_ID), .regwrite_ID(regwrite_ID),
        .memread_ID(memread_ID), .branch_taken_EX(branch_taken_EX), .mem_stall(mem_stall),
        .inst_data_EX(s_ex), .inst_data_MEM(s_mem), .inst_data_WB(s_wb),
        .regwrite_MEM(s_rwm), .regwrite_WB(s_rww), .memread_EX(s_mrx),
        .stall_IF_ID(s_st), .flush_IF_ID(s_fl),
        .stall_cnt(s_sc), .flush_cnt(s_fc)
    );

    typedef struct {
        logic        rst;
        logic [31:0] inst;
        logic        rw, mr, br, ms;
        logic        e_st, e_fl;
        logic [31:0] e_ex, e_mem, e_wb;
        logic        e_rwm, e_rww, e_mrx;
        logic [15:0] e_sc, e_fc;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic drive(input logic r, input logic [31:0] inst, input logic rw, input logic mr,
                         input logic br, input logic ms);
        @(negedge clk);
        rst = r; inst_data_ID = inst; regwrite_ID = rw; memread_ID = mr;
        branch_taken_EX = br; mem_stall = ms;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rst inst rw mr br ms  st fl  ex   mem  wb   rwm rww mrx sc fc
        vecs[0]  = '{0, L5,  1, 1, 0, 0,  0, 0,  L5,  N,   N,   0, 0, 1,  0, 0};
        vecs[1]  = '{0, A6,  1, 0, 0, 0,  1, 0,  N,   L5,  N,   1, 0, 0,  1, 0};
        vecs[2]  = '{0, A6,  1, 0, 0, 0,  0, 0,  A6,  N,   L5,  0, 1, 0,  1, 0};
        vecs[3]  = '{0, L0,  1, 1, 0, 0,  0, 0,  L0,  A6,  N,   1, 0, 1,  1, 0};
        vecs[4]  = '{0, A60, 1, 0, 0, 0,  0, 0,  A60, L0,  A6,  1, 1, 0,  1, 0};
        vecs[5]  = '{0, L5,  1, 1, 0, 0,  0, 0,  L5,  A60, L0,  1, 1, 1,  1, 0};
        vecs[6]  = '{0, LUI, 1, 0, 0, 0,  0, 0,  LUI, L5,  A60, 1, 1, 0,  1, 0};
        vecs[7]  = '{0, L5,  1, 1, 0, 0,  0, 0,  L5,  LUI, L5,  1, 1, 1,  1, 0};
        vecs[8]  = '{0, A7,  1, 0, 0, 0,  1, 0,  N,   L5,  LUI, 1, 1, 0,  2, 0};
        vecs[9]  = '{0, A7,  1, 0, 0, 0,  0, 0,  A7,  N,   L5,  0, 1, 0,  2, 0};
        vecs[10] = '{0, L5,  1, 1, 0, 0,  0, 0,  L5,  A7,  N,   1, 0, 1,  2, 0};
        vecs[11] = '{0, AD8, 1, 0, 1, 0,  0, 1,  N,   L5,  A7,  1, 1, 0,  2, 1};
        vecs[12] = '{0, I1,  1, 0, 0, 1,  1, 0,  N,   L5,  A7,  1, 1, 0,  2, 1};
        vecs[13] = '{0, I1,  1, 0, 1, 1,  1, 0,  N,   L5,  A7,  1, 1, 0,  2, 1};
        vecs[14] = '{0, I1,  1, 0, 0, 1,  1, 0,  N,   L5,  A7,  1, 1, 0,  2, 1};
        vecs[15] = '{0, I1,  1, 0, 0, 0,  0, 0,  I1,  N,   L5,  0, 1, 0,  2, 1};
        vecs[16] = '{0, L5,  1, 1, 0, 0,  0, 0,  L5,  I1,  N,   1, 0, 1,  2, 1};
        vecs[17] = '{0, A6,  1, 0, 0, 1,  1, 0,  L5,  I1,  N,   1, 0, 1,  2, 1};
        vecs[18] = '{0, A6,  1, 0, 0, 0,  1, 0,  N,   L5,  I1,  1, 1, 0,  3, 1};
        vecs[19] = '{0, L5,  1, 1, 0, 0,  0, 0,  L5,  N,   L5,  0, 1, 1,  3, 1};
        vecs[20] = '{1, A6,  1, 0, 0, 0,  1, 0,  N,   N,   N,   0, 0, 0,  0, 0};
        vecs[21] = '{0, I1,  1, 0, 0, 0,  0, 0,  I1,  N,   N,   0, 0, 0,  0, 0};

        rst = 1'b1; inst_data_ID = N; regwrite_ID = 1'b0; memread_ID = 1'b0;
        branch_taken_EX = 1'b0; mem_stall = 1'b0;
        tick();
        drive(1, N, 0, 0, 0, 0);
        tick();
        drive(0, N, 0, 0, 0, 0);
        check("rst_ex",  -1, inst_data_EX, N);
        check("rst_mem", -1, inst_data_MEM, N);
        check("rst_wb",  -1, inst_data_WB, N);
        check("rst_rwm", -1, 32'(regwrite_MEM), 0);
        check("rst_rww", -1, 32'(regwrite_WB), 0);
        check("rst_mrx", -1, 32'(memread_EX), 0);
        check("rst_sc",  -1, 32'(stall_cnt), 0);
        check("rst_fc",  -1, 32'(flush_cnt), 0);
        check("rst_stall", -1, 32'(stall_IF_ID), 0);
        check("rst_flush", -1, 32'(flush_IF_ID), 0);

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].rst, vecs[i].inst, vecs[i].rw, vecs[i].mr, vecs[i].br, vecs[i].ms);
            check("stall_IF_ID", i, 32'(stall_IF_ID), 32'(vecs[i].e_st));
            check("flush_IF_ID", i, 32'(flush_IF_ID), 32'(vecs[i].e_fl));
            tick();
            check("inst_data_EX",  i, inst_data_EX,  vecs[i].e_ex);
            check("inst_data_MEM", i, inst_data_MEM, vecs[i].e_mem);
            check("inst_data_WB",  i, inst_data_WB,  vecs[i].e_wb);
            check("regwrite_MEM",  i, 32'(regwrite_MEM), 32'(vecs[i].e_rwm));
            check("regwrite_WB",   i, 32'(regwrite_WB),  32'(vecs[i].e_rww));
            check("memread_EX",    i, 32'(memread_EX),   32'(vecs[i].e_mrx));
            check("stall_cnt",     i, 32'(stall_cnt),    32'(vecs[i].e_sc));
            check("flush_cnt",     i, 32'(flush_cnt),    32'(vecs[i].e_fc));
        end

        // Saturation: both instances start from zero after the reset row.
        for (int k = 1; k <= 4; k++) begin
            drive(0, L5, 1, 1, 0, 0);
            tick();
            drive(0, A6, 1, 0, 0, 0);
            check("sat_stall_req", k, 32'(stall_IF_ID), 1);
            tick();
            check("sat_stall_cnt16", k, 32'(stall_cnt), k);
            check("sat_stall_cnt2",  k, 32'(s_sc), (k > 3) ? 3 : k);
        end
        for (int k = 1; k <= 4; k++) begin
            drive(0, I1, 1, 0, 1, 0);
            check("sat_flush_req", k, 32'(flush_IF_ID), 1);
            tick();
            check("sat_flush_cnt16", k, 32'(flush_cnt), k);
            check("sat_flush_cnt2",  k, 32'(s_fc), (k > 3) ? 3 : k);
            check("sat_flush_ex",    k, inst_data_EX, N);
        end
        check("sat_stall_hold2", 0, 32'(s_sc), 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
